pix_collect: RTL and testbench

//  Result-side counterpart of the work-dispatcher pixel counter: accepts finished (x,y,iter) results

---
 rtl/pix_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/pix_collect.sv | 144 ++++++++++++++
 tb/tb_pix_collect.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pix_pkg.sv
// Shared types and helpers for the pixel result collector.
package pix_pkg;

  localparam int NUM_CNT_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WRITE
  } collect_state_t;

  function automatic int unsigned total_pixels(input int unsigned x_max, input int unsigned y_max);
    return (x_max + 1) * (y_max + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted requester.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N-1:0]                          req,
  input  logic                                  advance,
  output logic [N-1:0]                          grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  grant_idx
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  int            idx;

  // Walk from the far end back toward ptr so the requester nearest ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pix_collect.sv
// Collects finished pixel results from several workers, computes the framebuffer
// address and writes each pixel through a single-outstanding acknowledged port.
module pix_collect #(
  parameter int NUM_CNT_BITS = pix_pkg::NUM_CNT_BITS,
  parameter int NUM_WORKERS  = 4,
  parameter int ITER_BITS    = 8,
  parameter int ADDR_BITS    = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic [NUM_CNT_BITS-1:0]           x_max,
  input  logic [NUM_CNT_BITS-1:0]           y_max,
  input  logic [NUM_WORKERS-1:0]            res_valid,
  input  logic [NUM_WORKERS*NUM_CNT_BITS-1:0] res_x,
  input  logic [NUM_WORKERS*NUM_CNT_BITS-1:0] res_y,
  input  logic [NUM_WORKERS*ITER_BITS-1:0]  res_iter,
  output logic [NUM_WORKERS-1:0]            res_ready,
  output logic                              mem_wr_en,
  output logic [ADDR_BITS-1:0]              mem_addr,
  output logic [ITER_BITS-1:0]              mem_data,
  input  logic                              mem_ack,
  output logic [2*NUM_CNT_BITS-1:0]         pix_count,
  output logic                              frame_done,
  output logic                              range_err
);

  import pix_pkg::*;

  localparam int W  = NUM_CNT_BITS;
  localparam int IW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int PW = 2 * NUM_CNT_BITS;

  collect_state_t   state, state_next;
  logic [NUM_WORKERS-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             accept;
  logic [W-1:0]     cap_x, cap_y;
  logic [ITER_BITS-1:0] cap_iter;
  logic             clear_pend;
  logic             in_range;
  logic [ADDR_BITS-1:0] row_len, addr_calc;
  logic [PW-1:0]    total_pix, pix_next;

  rr_arbiter #(.N(NUM_WORKERS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (res_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A frame restart or a finished frame blocks new results from being taken.
  assign accept    = (state == IDLE) && (|res_valid) && !frame_done && !clear;
  assign res_ready = accept ? grant : '0;
  assign mem_wr_en = (state == WRITE);

  assign in_range  = (cap_x <= x_max) && (cap_y <= y_max);
  assign row_len   = ADDR_BITS'(x_max) + ADDR_BITS'(1);
  assign addr_calc = ADDR_BITS'(cap_y) * row_len + ADDR_BITS'(cap_x);
  assign total_pix = PW'(total_pixels(32'(x_max), 32'(y_max)));
  assign pix_next  = pix_count + PW'(1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    state_next = (clear || !in_range) ? IDLE : WRITE;
      WRITE:   if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_x    <= '0;
      cap_y    <= '0;
      cap_iter <= '0;
    end else if (accept) begin
      cap_x    <= res_x[int'(grant_idx)*W +: W];
      cap_y    <= res_y[int'(grant_idx)*W +: W];
      cap_iter <= res_iter[int'(grant_idx)*ITER_BITS +: ITER_BITS];
    end
  end

  // A clear arriving mid-write waits for the ack so the memory transaction is never torn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_data   <= '0;
      pix_count  <= '0;
      frame_done <= 1'b0;
      range_err  <= 1'b0;
      clear_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            pix_count  <= '0;
            frame_done <= 1'b0;
            range_err  <= 1'b0;
          end
        end
        CALC: begin
          if (clear) begin
            pix_count  <= '0;
            frame_done <= 1'b0;
            range_err  <= 1'b0;
          end else begin
            mem_addr <= addr_calc;
            mem_data <= cap_iter;
            if (!in_range) range_err <= 1'b1;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            if (clear_pend || clear) begin
              pix_count  <= '0;
              frame_done <= 1'b0;
              range_err  <= 1'b0;
              clear_pend <= 1'b0;
            end else begin
              pix_count <= pix_next;
              if (pix_next == total_pix) frame_done <= 1'b1;
            end
          end else if (clear) begin
            clear_pend <= 1'b1;
          end
        end
        default: clear_pend <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pix_collect.sv
// Scoreboard bench for pix_collect: expected grants and writes are queued by the
// stimulus and consumed by a monitor whenever the DUT handshakes.
module tb_pix_collect;

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] iter;
  } res_t;

  logic        clk, rst, clear, mem_ack, mem_wr_en, frame_done, range_err;
  logic [9:0]  x_max, y_max;
  logic [3:0]  res_valid, res_ready;
  logic [39:0] res_x, res_y;
  logic [31:0] res_iter;
  logic [19:0] mem_addr, pix_count;
  logic [7:0]  mem_data;

  res_t wq[4][$];
  wr_t  exp_wr[$];
  int   exp_grant[$];
  int   grant_cycles[$];
  logic [3:0] acc;
  int   cycle, grant_cnt, wr_seen, ack_delay, wait_cnt;
  int   n_cmp, n_err;

  pix_collect #(
    .NUM_CNT_BITS(10), .NUM_WORKERS(4), .ITER_BITS(8), .ADDR_BITS(20)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .x_max(x_max), .y_max(y_max),
    .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_iter(res_iter),
    .res_ready(res_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .pix_count(pix_count),
    .frame_done(frame_done), .range_err(range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int w, input int x, input int y, input int iter);
    res_t r;
    r.x = 10'(x);
    r.y = 10'(y);
    r.iter = 8'(iter);
    wq[w].push_back(r);
  endtask

  task automatic expectWrite(input int addr, input int data);
    wr_t e;
    e.addr = 20'(addr);
    e.data = 8'(data);
    exp_wr.push_back(e);
  endtask

  task automatic flushAll();
    for (int w = 0; w < 4; w++) wq[w].delete();
    exp_wr.delete();
    exp_grant.delete();
    acc = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    flushAll();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic bit busy();
    return exp_grant.size() != 0 || exp_wr.size() != 0 || wq[0].size() != 0 ||
           wq[1].size() != 0 || wq[2].size() != 0 || wq[3].size() != 0;
  endfunction

  task automatic waitDrain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) checkOutput("drain_timeout", 1, 0);
    tick();
    tick();
  endtask

  task automatic waitWrEn(input int budget);
    int n = 0;
    while (!mem_wr_en && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) checkOutput("wr_en_timeout", 1, 0);
  endtask

  // Worker model: present the head of each queue until the DUT accepts it.
  initial begin
    res_valid = '0;
    res_x = '0;
    res_y = '0;
    res_iter = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int w = 0; w < 4; w++) begin
        if (acc[w] && wq[w].size() > 0) void'(wq[w].pop_front());
        acc[w] = 1'b0;
        if (wq[w].size() > 0) begin
          res_valid[w] = 1'b1;
          res_x[w*10 +: 10]  = wq[w][0].x;
          res_y[w*10 +: 10]  = wq[w][0].y;
          res_iter[w*8 +: 8] = wq[w][0].iter;
        end else begin
          res_valid[w] = 1'b0;
        end
      end
    end
  end

  // Memory model: acknowledge after ack_delay cycles of a held request.
  initial begin
    mem_ack = 1'b0;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_wr_en && !mem_ack) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pop and compare on every accept pulse and every acknowledged write.
  initial begin
    wr_t e;
    int  g;
    forever begin
      @(negedge clk);
      if (!rst && |res_ready) begin
        grant_cnt++;
        grant_cycles.push_back(cycle);
        for (int w = 0; w < 4; w++)
          if (res_ready[w] && res_valid[w]) acc[w] = 1'b1;
        if (exp_grant.size() == 0) begin
          checkOutput("unexpected_ready", 32'(res_ready), 0);
        end else begin
          g = exp_grant.pop_front();
          checkOutput("grant", 32'(res_ready), 32'(1) << g);
        end
      end
      if (mem_wr_en) wr_seen++;
      if (mem_wr_en && mem_ack) begin
        if (exp_wr.size() == 0) begin
          checkOutput("unexpected_write", 32'(mem_addr), 32'hFFFFFFFF);
        end else begin
          e = exp_wr.pop_front();
          checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
          checkOutput("wr_data", 32'(mem_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gc, ws, gs;
    n_cmp = 0;
    n_err = 0;
    grant_cnt = 0;
    wr_seen = 0;
    cycle = 0;
    acc = '0;
    rst = 1'b1;
    clear = 1'b0;
    x_max = 10'd3;
    y_max = 10'd1;
    ack_delay = 0;
    tick();
    tick();
    checkOutput("rst_res_ready", 32'(res_ready), 0);
    checkOutput("rst_wr_en", 32'(mem_wr_en), 0);
    checkOutput("rst_addr", 32'(mem_addr), 0);
    checkOutput("rst_data", 32'(mem_data), 0);
    checkOutput("rst_pix", 32'(pix_count), 0);
    checkOutput("rst_done", 32'(frame_done), 0);
    checkOutput("rst_err", 32'(range_err), 0);
    rst = 1'b0;
    tick();

    // Single result, one cycle of ack latency.
    $display("[TB] test 1: single result");
    ack_delay = 1;
    gc = grant_cnt;
    exp_grant.push_back(0);
    expectWrite(6, 'h5A);
    applyStimulus(0, 2, 1, 'h5A);
    waitDrain(40);
    checkOutput("t1_pix", 32'(pix_count), 1);
    checkOutput("t1_ready_pulses", 32'(grant_cnt - gc), 1);
    checkOutput("t1_wr_idle", 32'(mem_wr_en), 0);

    // Four continuously valid workers fill a 4x2 frame in round-robin order.
    $display("[TB] test 2: round robin");
    doReset();
    ack_delay = 0;
    gs = grant_cycles.size();
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 4; w++) begin
        exp_grant.push_back(w);
        expectWrite(k * 4 + w, k * 16 + w);
        applyStimulus(w, w, k, k * 16 + w);
      end
    waitDrain(200);
    checkOutput("t2_pix", 32'(pix_count), 8);
    checkOutput("t2_done", 32'(frame_done), 1);
    for (int i = 1; i < 8; i++)
      checkOutput("t2_spacing", 32'(grant_cycles[gs+i] - grant_cycles[gs+i-1]), 3);

    // Frame completion on a 2x2 frame, then stall and restart.
    $display("[TB] test 3: frame done");
    doReset();
    x_max = 10'd1;
    y_max = 10'd1;
    for (int w = 0; w < 4; w++) begin
      exp_grant.push_back(w);
      expectWrite(w, w + 1);
      applyStimulus(w, w % 2, w / 2, w + 1);
    end
    waitDrain(200);
    checkOutput("t3_done", 32'(frame_done), 1);
    checkOutput("t3_pix", 32'(pix_count), 4);
    applyStimulus(1, 1, 1, 'h77);
    repeat (10) tick();
    checkOutput("t3_stalled", 32'(wq[1].size()), 1);
    checkOutput("t3_no_ready", 32'(res_ready), 0);
    exp_grant.push_back(1);
    expectWrite(3, 'h77);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    waitDrain(60);
    checkOutput("t3_pix_after_clear", 32'(pix_count), 1);
    checkOutput("t3_done_after_clear", 32'(frame_done), 0);

    // Out-of-range coordinates are flagged and never written.
    $display("[TB] test 4: range error");
    x_max = 10'd3;
    y_max = 10'd1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    ws = wr_seen;
    exp_grant.push_back(2);
    applyStimulus(2, 5, 0, 'h33);
    waitDrain(60);
    checkOutput("t4_err_x", 32'(range_err), 1);
    checkOutput("t4_pix", 32'(pix_count), 0);
    checkOutput("t4_no_write", 32'(wr_seen - ws), 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("t4_err_cleared", 32'(range_err), 0);
    exp_grant.push_back(2);
    applyStimulus(2, 0, 2, 'h34);
    waitDrain(60);
    checkOutput("t4_err_y", 32'(range_err), 1);
    checkOutput("t4_no_write_y", 32'(wr_seen - ws), 0);
    exp_grant.push_back(2);
    expectWrite(7, 'h35);
    applyStimulus(2, 3, 1, 'h35);
    waitDrain(60);
    checkOutput("t4_corner_pix", 32'(pix_count), 1);

    // Clear during a slow write completes the write, then zeroes the count.
    $display("[TB] test 5: clear during write");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_grant.push_back(3);
    expectWrite(0, 'h21);
    applyStimulus(3, 0, 0, 'h21);
    waitDrain(60);
    checkOutput("t5_pix_before", 32'(pix_count), 1);
    ack_delay = 5;
    exp_grant.push_back(0);
    expectWrite(5, 'h44);
    applyStimulus(0, 1, 1, 'h44);
    waitWrEn(40);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    checkOutput("t5_wr_held", 32'(mem_wr_en), 1);
    checkOutput("t5_addr_held", 32'(mem_addr), 5);
    waitDrain(60);
    checkOutput("t5_pix_after", 32'(pix_count), 0);
    checkOutput("t5_wr_idle", 32'(mem_wr_en), 0);

    // Reset in the middle of a write, then a clean transaction.
    $display("[TB] test 6: reset during write");
    ack_delay = 10;
    exp_grant.push_back(1);
    expectWrite(7, 'h66);
    applyStimulus(1, 3, 1, 'h66);
    waitWrEn(40);
    rst = 1'b1;
    #1;
    checkOutput("t6_wr_en", 32'(mem_wr_en), 0);
    checkOutput("t6_addr", 32'(mem_addr), 0);
    checkOutput("t6_data", 32'(mem_data), 0);
    checkOutput("t6_pix", 32'(pix_count), 0);
    flushAll();
    tick();
    rst = 1'b0;
    tick();
    ack_delay = 0;
    exp_grant.push_back(0);
    expectWrite(1, 'h12);
    applyStimulus(0, 1, 0, 'h12);
    waitDrain(60);
    checkOutput("t6_resume_pix", 32'(pix_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
